// File: rtl/pipe_fifo_if.sv
// Handshake bundle for pipe_fifo: valid/ready write side, valid/ready read side
// and the occupancy count. The FIFO sits on the slave modport.
interface pipe_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/pipe_fifo.sv
// First-word-fall-through FIFO with power-of-two depth and a synchronous
// active-low reset; only pointers and count are reset, storage is not.
module pipe_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input logic         clk,
  input logic         rst_n,
  pipe_fifo_if.slave  bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push;
  logic             pop;

  // Ready is gated by reset so nothing is accepted while rst_n is low, and a
  // full FIFO refuses even when a pop happens in the same cycle.
  assign bus.in_ready  = (count_q < FULL_COUNT) && rst_n;
  assign bus.out_valid = (count_q != '0);
  assign bus.out_data  = mem_q[rd_ptr_q];
  assign bus.count     = count_q;

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end
endmodule

// File: doc/pipe_fifo.md
PIPE_FIFO -- requirements
Module: pipe_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits.
REQ-002 Parameter DEPTH, default 4, number of entries; power of two, >= 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low; sampled on posedge clk.
REQ-005 in_valid  input  1  upstream presents in_data this cycle.
REQ-006 in_ready  output  1  FIFO accepts a word this cycle.
REQ-007 in_data  input  WIDTH  write data.
REQ-008 out_valid  output  1  out_data holds the oldest stored word.
REQ-009 out_ready  input  1  downstream consumes out_data this cycle; drives the enable of the downstream 8-bit enabled pipeline register.
REQ-010 out_data  output  WIDTH  oldest stored word.
REQ-011 count  output  $clog2(DEPTH+1)  number of stored words.

Function
REQ-012 push = in_valid & in_ready; pop = out_valid & out_ready; both evaluated each cycle.
REQ-013 in_ready SHALL be combinational: 1 iff count < DEPTH and rst_n = 1.
REQ-014 out_valid SHALL be 1 iff count != 0.
REQ-015 First-word-fall-through: out_data SHALL equal mem[rd_ptr] combinationally; value is don't-care when out_valid = 0.
REQ-016 Latency: a word pushed at edge N SHALL be visible on out_data with out_valid = 1 after edge N; no same-cycle bypass from in_data to out_data.
REQ-017 Push: mem[wr_ptr] <= in_data, wr_ptr <= wr_ptr + 1 modulo DEPTH.
REQ-018 Pop: rd_ptr <= rd_ptr + 1 modulo DEPTH.
REQ-019 count update: push only +1; pop only -1; push and pop together or neither: unchanged.
REQ-020 Full (count = DEPTH): in_ready = 0; a simultaneous pop SHALL NOT enable a same-cycle push (no pass-through when full).
REQ-021 Empty (count = 0): out_valid = 0; out_ready ignored; count SHALL NOT underflow.
REQ-022 Words SHALL leave in exactly the order they entered, across pointer wrap-around.
REQ-023 While out_valid = 1 and out_ready = 0, out_data and out_valid SHALL stay stable, whatever the push activity.
REQ-024 in_valid while in_ready = 0 SHALL have no effect on state.
REQ-025 Storage array needs no reset; only pointers and count are reset.

Reset
REQ-026 rst_n = 0 at a rising edge SHALL set rd_ptr = 0, wr_ptr = 0, count = 0; after that edge out_valid = 0.
REQ-027 Reset SHALL take priority over any push/pop in the same cycle; in-flight contents are discarded.
REQ-028 in_ready SHALL be 0 while rst_n = 0; first push is possible in the first cycle with rst_n = 1.
REQ-029 Reset asserted mid-operation (count > 0) SHALL yield count = 0 and out_valid = 0 after the edge, with no stale word ever presented afterwards.

Verification
REQ-030 Reset 3 cycles, release -> count = 0, out_valid = 0, in_ready = 1.
REQ-031 Push 0x12 with out_ready = 0 -> next cycle out_valid = 1, out_data = 0x12, count = 1; hold 3 cycles -> out_data stays 0x12.
REQ-032 Push 0x11,0x22,0x33,0x44 with out_ready = 0 -> count = 4, in_ready = 0; extra push of 0x55 ignored; pop 4 -> outputs 0x11,0x22,0x33,0x44, then out_valid = 0.
REQ-033 Full, in_valid = 1 (0x66) and out_ready = 1 same cycle -> pop of head only, count = 3; 0x66 accepted next cycle -> count = 4.
REQ-034 Streaming 10 words 0xA0..0xA9 with in_valid = out_ready = 1 -> output order 0xA0..0xA9 across wrap, count settles at 1 during streaming, 0 at end.
REQ-035 Load 0xAB,0xCD (count = 2), assert rst_n = 0 one cycle with push 0xEF -> count = 0, out_valid = 0; then push 0x56 -> out_data = 0x56 next cycle.
